prio_arb_mux: RTL and testbench
===============================

# prio_arb_mux

Registered, flow-controlled successor to the combinational priority multiplexer. Selects one of INPUTS valid/ready source channels per cycle, with fixed priority (lower index wins) or round-robin arbitration. Moves the winning beat into a single output register with valid/ready backpressure. Sits between multiple request producers and one shared downstream consumer, such as a bus master port or a write-back path.

## Interface
Parameters:
- INPUTS, 19, number of source channels (≥1; need not be a power of two)
- WIDTH, 32, data bits per channel
- ROUND_ROBIN, 0, 0 = fixed priority (index 0 highest), 1 = round-robin
- IDXW, $clog2(INPUTS) (min 1), derived, width of o_index

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- i_valid  in  INPUTS  per-channel request valid
- i_data  in  [INPUTS-1:0][WIDTH-1:0]  per-channel data, packed
- i_ready  out  INPUTS  per-channel accept; at most one bit high
- o_valid  out  1  output register holds a beat
- o_data  out  WIDTH  registered winning data
- o_index  out  IDXW  registered index of the winning channel
- o_grant  out  INPUTS  registered one-hot copy of o_index
- o_ready  in  1  downstream accepts the beat

## Operation
- load = ~o_valid | o_ready. The output register may be written only when load = 1.
- Winner selection is combinational from i_valid and the rotation pointer ptr:
  - Fixed mode: the lowest set index of i_valid.
  - Round-robin mode: the first set index scanning ptr, ptr+1, … INPUTS-1, 0, … ptr-1.
- i_ready[k] = load & ~rst & (k == winner) & i_valid[k]. No i_ready bit is ever high for a non-valid channel.
- On a cycle with load = 1 and any i_valid set:
  - o_data <= i_data[winner], o_index <= winner, o_grant <= one-hot(winner), o_valid <= 1.
  - Round-robin mode: ptr <= (winner == INPUTS-1) ? 0 : winner+1. Fixed mode: ptr is unused and held at 0.
- On a cycle with load = 1 and no i_valid set: o_valid <= 0. o_data, o_index and o_grant hold their last values.
- On a cycle with load = 0 (o_valid & ~o_ready): all registers hold. o_data, o_index and o_grant stay stable while o_valid = 1.
- A source beat transfers on i_valid[k] & i_ready[k]. An output beat transfers on o_valid & o_ready.
- Combinational paths i_valid→i_ready and o_ready→i_ready are permitted. There is no path from i_data to any output except through the register.
- INPUTS = 1: channel 0 always wins, and o_index is a constant 0.

## Timing
- Reset values: o_valid 0, o_data 0, o_index 0, o_grant 0, ptr 0. i_ready is forced to 0 while rst = 1.
- Latency: a source beat accepted in cycle n appears on the outputs in cycle n+1.
- Throughput: 1 beat/cycle sustained while o_ready = 1. No bubble is inserted when the register is drained and refilled in the same cycle.
- Simultaneous drain and fill (o_valid & o_ready & some i_valid): the new beat replaces the old one in the same edge, and o_valid stays 1.
- Round-robin pointer wrap: after channel INPUTS-1 is granted, ptr = 0.
- Reset asserted mid-stream:
  - Any beat in the output register is discarded.
  - No i_ready is issued during reset.
  - Arbitration restarts from ptr = 0 on the first cycle after rst falls.
- ptr changes only on a cycle in which a source beat transfers. Backpressure does not advance the rotation.

## Test plan
- Reset check: hold rst 3 cycles with all i_valid = 1 → i_ready = 0, and o_valid/o_data/o_index/o_grant = 0. First cycle after release with o_ready = 1 → i_ready = 1<<0.
- Fixed priority, INPUTS = 19: i_valid = 19'h40028 held, o_ready = 1 → i_ready = 1<<3 every cycle, o_index = 3, o_data = i_data[3] one cycle later.
- Round robin, INPUTS = 5: i_valid = 5'b10101 held, o_ready = 1 → o_index sequence 0, 2, 4, 0, 2 (pointer wrap), one per cycle with no bubbles.
- Backpressure: accept data 32'hDEADBEEF from channel 7, then hold o_ready = 0 for 4 cycles → o_data/o_index stable, i_ready = 0, ptr unchanged. Raise o_ready → the next beat loads on that same edge.
- Idle drain: a single beat from channel 2, then i_valid = 0 with o_ready = 1 → o_valid falls the cycle after the transfer. o_index stays 2.
- Reset mid-stream: in round robin, after granting channel 3, assert rst while o_valid = 1 → o_valid = 0 next cycle. After release with all i_valid = 1, channel 0 wins.

Source files
------------

// File: rtl/prio_arb_mux.sv
// Registered valid/ready arbiter-mux: picks one source channel per cycle
// (fixed priority or round-robin) and holds the winning beat in an output register.
module prio_arb_mux #(
   parameter int INPUTS      = 19,
   parameter int WIDTH       = 32,
   parameter int ROUND_ROBIN = 0,
   parameter int IDXW        = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [INPUTS-1:0]              i_valid,
   input  logic [INPUTS-1:0][WIDTH-1:0]   i_data,
   output logic [INPUTS-1:0]              i_ready,
   output logic                           o_valid,
   output logic [WIDTH-1:0]               o_data,
   output logic [IDXW-1:0]                o_index,
   output logic [INPUTS-1:0]              o_grant,
   input  logic                           o_ready
);

   logic                 o_valid_q, o_valid_d;
   logic [WIDTH-1:0]     o_data_q, o_data_d;
   logic [IDXW-1:0]      o_index_q, o_index_d;
   logic [INPUTS-1:0]    o_grant_q, o_grant_d;
   logic [IDXW-1:0]      ptr_q, ptr_d;

   logic                 load;
   logic [INPUTS-1:0]    hi_mask;
   logic [INPUTS-1:0]    masked;
   logic [INPUTS-1:0]    sel;
   logic [IDXW-1:0]      win;
   logic [INPUTS-1:0]    win_oh;
   logic [WIDTH-1:0]     win_data;

   // Requests at or above ptr take precedence; otherwise wrap to the lowest index.
   // With ptr pinned at 0 this collapses to plain fixed priority.
   always_comb begin
      hi_mask = '0;
      for (int k = 0; k < INPUTS; k++) begin
         hi_mask[k] = (k >= int'(ptr_q));
      end
      masked = i_valid & hi_mask;
      sel    = (|masked) ? masked : i_valid;

      win = '0;
      for (int k = INPUTS - 1; k >= 0; k--) begin
         if (sel[k]) win = IDXW'(k);
      end

      win_oh   = '0;
      win_data = '0;
      for (int k = 0; k < INPUTS; k++) begin
         if (win == IDXW'(k)) begin
            win_oh[k] = 1'b1;
            win_data  = i_data[k];
         end
      end
   end

   assign load    = ~o_valid_q | o_ready;
   assign i_ready = win_oh & i_valid & {INPUTS{load & ~rst}};

   always_comb begin
      o_valid_d = o_valid_q;
      o_data_d  = o_data_q;
      o_index_d = o_index_q;
      o_grant_d = o_grant_q;
      ptr_d     = ptr_q;
      if (load) begin
         if (|i_valid) begin
            o_valid_d = 1'b1;
            o_data_d  = win_data;
            o_index_d = win;
            o_grant_d = win_oh;
            if (ROUND_ROBIN != 0) begin
               ptr_d = (win == IDXW'(INPUTS - 1)) ? '0 : win + IDXW'(1);
            end else begin
               ptr_d = '0;
            end
         end else begin
            o_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         o_index_q <= '0;
         o_grant_q <= '0;
         ptr_q     <= '0;
      end else begin
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
         o_index_q <= o_index_d;
         o_grant_q <= o_grant_d;
         ptr_q     <= ptr_d;
      end
   end

   assign o_valid = o_valid_q;
   assign o_data  = o_data_q;
   assign o_index = o_index_q;
   assign o_grant = o_grant_q;

endmodule

// File: tb/tb_prio_arb_mux.sv
// Bench for prio_arb_mux: a fixed-priority 19-channel instance and a
// round-robin 5-channel instance, checked through per-instance scoreboards.
module tb_prio_arb_mux;

   typedef struct {
      int          idx;
      logic [31:0] data;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic                rst_f, ordy_f, ov_f;
   logic [18:0]         vld_f, rdy_f, og_f;
   logic [18:0][31:0]   dat_f;
   logic [31:0]         od_f;
   logic [4:0]          oi_f;

   logic                rst_r, ordy_r, ov_r;
   logic [4:0]          vld_r, rdy_r, og_r;
   logic [4:0][31:0]    dat_r;
   logic [31:0]         od_r;
   logic [2:0]          oi_r;

   beat_t exp_f[$];
   beat_t exp_r[$];
   beat_t bf, br;

   prio_arb_mux #(.INPUTS(19), .WIDTH(32), .ROUND_ROBIN(0)) dut_f (
      .clk(clk), .rst(rst_f), .i_valid(vld_f), .i_data(dat_f),
      .i_ready(rdy_f), .o_valid(ov_f), .o_data(od_f), .o_index(oi_f),
      .o_grant(og_f), .o_ready(ordy_f)
   );

   prio_arb_mux #(.INPUTS(5), .WIDTH(32), .ROUND_ROBIN(1)) dut_r (
      .clk(clk), .rst(rst_r), .i_valid(vld_r), .i_data(dat_r),
      .i_ready(rdy_r), .o_valid(ov_r), .o_data(od_r), .o_index(oi_r),
      .o_grant(og_r), .o_ready(ordy_r)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
      n_tests++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   // Drive one cycle on both instances; ef/er is the channel expected to be accepted (-1 = none).
   task automatic step(input logic [18:0] vf, input logic orf, input int ef,
                       input logic [4:0] vr, input logic orr, input int er);
      logic [18:0] ref_f;
      logic [4:0]  ref_r;
      vld_f = vf; ordy_f = orf;
      vld_r = vr; ordy_r = orr;
      ref_f = '0;
      ref_r = '0;
      if (ef >= 0) ref_f[ef] = 1'b1;
      if (er >= 0) ref_r[er] = 1'b1;
      @(negedge clk);
      chk("f_i_ready", 64'(rdy_f), 64'(ref_f));
      chk("r_i_ready", 64'(rdy_r), 64'(ref_r));
      if (ef >= 0) exp_f.push_back('{ef, dat_f[ef]});
      if (er >= 0) exp_r.push_back('{er, dat_r[er]});
      @(posedge clk);
      #1;
   endtask

   task automatic out_f(input string name, input logic v, input int idx,
                        input logic [31:0] d, input logic [18:0] g);
      chk({name, "_valid"}, 64'(ov_f), 64'(v));
      chk({name, "_index"}, 64'(oi_f), 64'(idx));
      chk({name, "_data"},  64'(od_f), 64'(d));
      chk({name, "_grant"}, 64'(og_f), 64'(g));
   endtask

   task automatic out_r(input string name, input logic v, input int idx,
                        input logic [31:0] d, input logic [4:0] g);
      chk({name, "_valid"}, 64'(ov_r), 64'(v));
      chk({name, "_index"}, 64'(oi_r), 64'(idx));
      chk({name, "_data"},  64'(od_r), 64'(d));
      chk({name, "_grant"}, 64'(og_r), 64'(g));
   endtask

   always @(negedge clk) begin
      if (!rst_f && ov_f && ordy_f) begin
         if (exp_f.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL f_unexpected_beat: got index %0d, required no beat", oi_f);
         end else begin
            bf = exp_f.pop_front();
            chk("f_sb_index", 64'(oi_f), 64'(bf.idx));
            chk("f_sb_data",  64'(od_f), 64'(bf.data));
            chk("f_sb_grant", 64'(og_f), 64'(1) << bf.idx);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_r && ov_r && ordy_r) begin
         if (exp_r.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL r_unexpected_beat: got index %0d, required no beat", oi_r);
         end else begin
            br = exp_r.pop_front();
            chk("r_sb_index", 64'(oi_r), 64'(br.idx));
            chk("r_sb_data",  64'(od_r), 64'(br.data));
            chk("r_sb_grant", 64'(og_r), 64'(1) << br.idx);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int k = 0; k < 19; k++) dat_f[k] = 32'h1000_0000 + k * 32'h0001_0101;
      dat_f[7] = 32'hDEAD_BEEF;
      for (int k = 0; k < 5; k++) dat_r[k] = 32'hC0DE_0000 + k;

      // reset held with every source requesting
      rst_f = 1'b1; rst_r = 1'b1;
      repeat (3) begin
         step('1, 1'b1, -1, '1, 1'b1, -1);
         out_f("f_rst", 1'b0, 0, 32'h0, 19'h0);
         out_r("r_rst", 1'b0, 0, 32'h0, 5'h0);
      end
      rst_f = 1'b0; rst_r = 1'b0;
      step('1, 1'b1, 0, '1, 1'b1, 0);
      out_f("f_rel", 1'b1, 0, dat_f[0], 19'h1);
      out_r("r_rel", 1'b1, 0, dat_r[0], 5'h1);

      // fixed priority: lowest set index of 19'h40028 is 3
      repeat (5) begin
         step(19'h40028, 1'b1, 3, 5'h0, 1'b1, -1);
         out_f("f_prio", 1'b1, 3, dat_f[3], 19'h8);
      end

      // backpressure with channel 7 held in the register
      step(19'h80, 1'b1, 7, 5'h0, 1'b1, -1);
      out_f("f_bp_load", 1'b1, 7, 32'hDEAD_BEEF, 19'h80);
      repeat (4) begin
         step(19'h280, 1'b0, -1, 5'h0, 1'b1, -1);
         out_f("f_bp_hold", 1'b1, 7, 32'hDEAD_BEEF, 19'h80);
      end
      step(19'h200, 1'b1, 9, 5'h0, 1'b1, -1);
      out_f("f_bp_refill", 1'b1, 9, dat_f[9], 19'h200);

      // single beat from channel 2 then idle
      step(19'h4, 1'b1, 2, 5'h0, 1'b1, -1);
      out_f("f_one", 1'b1, 2, dat_f[2], 19'h4);
      step(19'h0, 1'b1, -1, 5'h0, 1'b1, -1);
      out_f("f_drain", 1'b0, 2, dat_f[2], 19'h4);

      // round robin from a fresh pointer: 0,2,4,0,2
      rst_r = 1'b1;
      step(19'h0, 1'b1, -1, 5'h0, 1'b1, -1);
      rst_r = 1'b0;
      foreach (exp_r[i]) chk("r_pre_rr_queue", 64'(exp_r.size()), 64'(0));
      begin
         int seq[5] = '{0, 2, 4, 0, 2};
         for (int i = 0; i < 5; i++) begin
            step(19'h0, 1'b1, -1, 5'b10101, 1'b1, seq[i]);
            out_r("r_rr", 1'b1, seq[i], dat_r[seq[i]], 5'(1 << seq[i]));
         end
      end

      // stall must not move the pointer (still 3 after granting 2)
      repeat (2) begin
         step(19'h0, 1'b1, -1, 5'b11111, 1'b0, -1);
         out_r("r_stall", 1'b1, 2, dat_r[2], 5'h4);
      end
      step(19'h0, 1'b1, -1, 5'b11111, 1'b1, 3);
      out_r("r_after_stall", 1'b1, 3, dat_r[3], 5'h8);

      // reset while channel 3 sits in the register
      rst_r = 1'b1;
      exp_r.delete();
      step(19'h0, 1'b1, -1, 5'b11111, 1'b0, -1);
      out_r("r_mid_rst", 1'b0, 0, 32'h0, 5'h0);
      rst_r = 1'b0;
      step(19'h0, 1'b1, -1, 5'b11111, 1'b1, 0);
      out_r("r_post_rst", 1'b1, 0, dat_r[0], 5'h1);
      step(19'h0, 1'b1, -1, 5'b11111, 1'b1, 1);
      out_r("r_post_rst2", 1'b1, 1, dat_r[1], 5'h2);

      step(19'h0, 1'b1, -1, 5'h0, 1'b1, -1);
      step(19'h0, 1'b1, -1, 5'h0, 1'b1, -1);
      chk("f_queue_empty", 64'(exp_f.size()), 64'(0));
      chk("r_queue_empty", 64'(exp_r.size()), 64'(0));
      chk("f_final_valid", 64'(ov_f), 64'(0));
      chk("r_final_valid", 64'(ov_r), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
